// File: rtl/upsampler_pkg.sv
// Shared types and constants for the zero-insert upsampler.
package upsampler_pkg;

    localparam int          COORD_W       = 16;
    localparam logic [15:0] FP16_POS_ZERO = 16'h0000;

    typedef enum logic [1:0] {
        EVEN_PIX  = 2'd0,
        EVEN_ZERO = 2'd1,
        ODD_ROW   = 2'd2
    } zi_state_t;

endpackage

// File: rtl/upsample_coord_counter.sv
// Output-raster coordinate counter: col steps on every emitted beat, rolls
// into row at the last column, and the whole frame wraps back to (0,0).
module upsample_coord_counter
    import upsampler_pkg::*;
#(
    parameter int OUT_W = 640,
    parameter int OUT_H = 480
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               adv_i,
    output logic [COORD_W-1:0] col_o,
    output logic [COORD_W-1:0] row_o,
    output logic               last_col_o
);

    localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(OUT_W - 1);
    localparam logic [COORD_W-1:0] ROW_MAX = COORD_W'(OUT_H - 1);

    logic [COORD_W-1:0] col_q, col_d;
    logic [COORD_W-1:0] row_q, row_d;
    logic               last_col;
    logic               last_row;
    logic               wrap;

    assign last_col = (col_q == COL_MAX);
    assign last_row = (row_q == ROW_MAX);
    assign wrap     = last_col && last_row;

    // Next coordinate: column increments, end of line bumps row, end of frame wraps.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (adv_i) begin
            if (last_col) begin
                col_d = '0;
                row_d = wrap ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Coordinate registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o      = col_q;
    assign row_o      = row_q;
    assign last_col_o = last_col;

endmodule

// File: rtl/zero_insert_upsampler_fp16.sv
// 2x zero-insertion upsampler for fp16 raster streams. Input pixels land on
// even (col,row); every other output position carries +0.0. Pixel bits pass
// through untouched.
// Optional build macro ZERO_INSERT_FRAME_FLAGS_EN adds sof_o / eol_o.
//
// state     | meaning
// EVEN_PIX  | even row, even col: waiting for an input pixel
// EVEN_ZERO | even row, odd col: emitting the inserted zero
// ODD_ROW   | odd row: emitting a full line of zeros
module zero_insert_upsampler_fp16
    import upsampler_pkg::*;
#(
    parameter int EXP_WIDTH    = 5,
    parameter int FRAC_WIDTH   = 10,
    parameter int IN_WIDTH     = 320,
    parameter int IN_HEIGHT    = 240,
    localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [FP_WIDTH_REG-1:0] data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [FP_WIDTH_REG-1:0] data_o,
    output logic [COORD_W-1:0]      col_o,
    output logic [COORD_W-1:0]      row_o,
`ifdef ZERO_INSERT_FRAME_FLAGS_EN
    output logic                    sof_o,
    output logic                    eol_o,
`endif
    output logic                    valid_o,
    input  logic                    ready_i
);

    localparam logic [FP_WIDTH_REG-1:0] ZERO_WORD = FP_WIDTH_REG'(FP16_POS_ZERO);

    zi_state_t                state_q, state_d;
    logic [FP_WIDTH_REG-1:0]  data_q;
    logic [COORD_W-1:0]       col_out_q, row_out_q;
    logic                     valid_q;
    logic                     advance;
    logic                     emit;
    logic                     load_pix;
    logic                     ready_c;
    logic [COORD_W-1:0]       cnt_col, cnt_row;
    logic                     last_col;

    assign advance = !valid_q || ready_i;

    upsample_coord_counter #(
        .OUT_W (2 * IN_WIDTH),
        .OUT_H (2 * IN_HEIGHT)
    ) u_coord (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .adv_i      (emit),
        .col_o      (cnt_col),
        .row_o      (cnt_row),
        .last_col_o (last_col)
    );

    // Next-state and beat generation; a beat is emitted whenever the output stage advances
    // and has something to carry (zeros always, pixels only when one is offered).
    always_comb begin
        state_d  = state_q;
        emit     = 1'b0;
        load_pix = 1'b0;
        ready_c  = 1'b0;
        case (state_q)
            EVEN_PIX: begin
                ready_c = advance;
                if (advance && valid_i) begin
                    emit     = 1'b1;
                    load_pix = 1'b1;
                    state_d  = EVEN_ZERO;
                end
            end
            EVEN_ZERO: begin
                if (advance) begin
                    emit    = 1'b1;
                    state_d = last_col ? ODD_ROW : EVEN_PIX;
                end
            end
            ODD_ROW: begin
                if (advance) begin
                    emit = 1'b1;
                    if (last_col) state_d = EVEN_PIX;
                end
            end
            default: state_d = EVEN_PIX;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= EVEN_PIX;
        else        state_q <= state_d;
    end

    // Output stage: loads on advance, holds while the downstream stalls.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            col_out_q <= '0;
            row_out_q <= '0;
        end else if (advance) begin
            valid_q <= emit;
            if (emit) begin
                data_q    <= load_pix ? data_i : ZERO_WORD;
                col_out_q <= cnt_col;
                row_out_q <= cnt_row;
            end
        end
    end

`ifdef ZERO_INSERT_FRAME_FLAGS_EN
    logic sof_q, eol_q;

    // Frame flags travel with the beat they describe.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sof_q <= 1'b0;
            eol_q <= 1'b0;
        end else if (advance && emit) begin
            sof_q <= (cnt_col == '0) && (cnt_row == '0);
            eol_q <= last_col;
        end
    end

    assign sof_o = sof_q;
    assign eol_o = eol_q;
`endif

    // The asynchronous reset also blocks acceptance combinationally.
    assign ready_o = rst_i && ready_c;
    assign data_o  = data_q;
    assign col_o   = col_out_q;
    assign row_o   = row_out_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_zero_insert_upsampler_fp16.sv
// Bench for zero_insert_upsampler_fp16 at W=2, H=2.
module tb_zero_insert_upsampler_fp16;

    localparam int W  = 2;
    localparam int H  = 2;
    localparam int OW = 2 * W;
    localparam int FB = 4 * W * H;

    logic        clk_i   = 1'b0;
    logic        rst_i   = 1'b0;
    logic [15:0] data_i  = '0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b1;
    logic        ready_o;
    logic [15:0] data_o;
    logic [15:0] col_o, row_o;
    logic        valid_o;
`ifdef ZERO_INSERT_FRAME_FLAGS_EN
    logic        sof_o, eol_o;
`endif

    zero_insert_upsampler_fp16 #(
        .IN_WIDTH  (W),
        .IN_HEIGHT (H)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .col_o   (col_o),
        .row_o   (row_o),
`ifdef ZERO_INSERT_FRAME_FLAGS_EN
        .sof_o   (sof_o),
        .eol_o   (eol_o),
`endif
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    initial forever #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model state: inputs accepted since reset, beats seen since reset.
    logic [15:0] acc_q[$];
    logic [15:0] log_d[$];
    int          log_c[$];
    int          log_r[$];
    int          k = 0;
    bit          tog = 1'b0;

    // Downstream ready: steady high, or alternating 1,0 when tog is set.
    initial forever begin
        @(posedge clk_i);
        #1;
        ready_i = tog ? ~ready_i : 1'b1;
    end

    // Compare process: every beat in the output raster is predicted from its
    // ordinal position and the list of accepted pixels.
    bit          held = 1'b0;
    logic [15:0] h_d, h_c, h_r;
    always @(negedge clk_i) begin
        int pos, r, c, idx;
        logic [15:0] exp_d;
        if (!rst_i) begin
            chk("rst_valid", valid_o, 0);
            chk("rst_data",  data_o,  0);
            chk("rst_col",   col_o,   0);
            chk("rst_row",   row_o,   0);
            chk("rst_ready", ready_o, 0);
            acc_q.delete();
            log_d.delete();
            log_c.delete();
            log_r.delete();
            k    = 0;
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", valid_o, 1);
                chk("hold_data",  data_o,  h_d);
                chk("hold_col",   col_o,   h_c);
                chk("hold_row",   row_o,   h_r);
            end
            held = 1'b0;
            if (valid_o && !ready_i) begin
                chk("stall_ready", ready_o, 0);
                held = 1'b1;
                h_d  = data_o;
                h_c  = col_o;
                h_r  = row_o;
            end
            if (valid_o && ready_i) begin
                pos   = k % FB;
                r     = pos / OW;
                c     = pos % OW;
                exp_d = 16'h0000;
                if ((r % 2 == 0) && (c % 2 == 0)) begin
                    idx = (k / FB) * (W * H) + (r / 2) * W + (c / 2);
                    if (idx < acc_q.size()) exp_d = acc_q[idx];
                    else begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL beat_src: beat %0d has no accepted input (got %h)", k, data_o);
                    end
                end
                chk("beat_data", data_o, exp_d);
                chk("beat_col",  col_o,  c);
                chk("beat_row",  row_o,  r);
`ifdef ZERO_INSERT_FRAME_FLAGS_EN
                chk("beat_sof", sof_o, (r == 0 && c == 0));
                chk("beat_eol", eol_o, (c == OW - 1));
`endif
                log_d.push_back(data_o);
                log_c.push_back(int'(col_o));
                log_r.push_back(int'(row_o));
                k++;
            end
            if (valid_i && ready_o) acc_q.push_back(data_i);
        end
    end

    task automatic send(input logic [15:0] d, input int gap);
        int t;
        bit acc;
        t   = 0;
        acc = 1'b0;
        valid_i = 1'b0;
        repeat (gap) begin
            @(posedge clk_i);
            #1;
        end
        valid_i = 1'b1;
        data_i  = d;
        while (!acc && t < 200) begin
            @(negedge clk_i);
            acc = ready_o;
            @(posedge clk_i);
            #1;
            t++;
        end
        valid_i = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: pixel %h not accepted, got none expected accept", d);
        end
    endtask

    task automatic wait_k(input int target);
        int t;
        t = 0;
        while (k < target && t < 500) begin
            @(negedge clk_i);
            t++;
        end
        n_checks++;
        if (k < target) begin
            n_fail++;
            $display("FAIL beat_timeout: got %0d beats expected %0d", k, target);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("ready_after_rst", ready_o, 1);
        @(posedge clk_i);
        #1;
    endtask

    logic [15:0] f1[4]   = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
    logic [15:0] exp16[16] = '{16'h3C00, 16'h0000, 16'h4000, 16'h0000,
                               16'h0000, 16'h0000, 16'h0000, 16'h0000,
                               16'h4200, 16'h0000, 16'h4400, 16'h0000,
                               16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] f3[4]   = '{16'h3555, 16'h3666, 16'h3777, 16'h3888};
    logic [15:0] f4[8]   = '{16'h1111, 16'h1222, 16'h1333, 16'h1444,
                             16'h2111, 16'h2222, 16'h2333, 16'h2444};
    logic [15:0] f5[4]   = '{16'h7E00, 16'h8000, 16'h7C00, 16'h0001};

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("ready_after_rst", ready_o, 1);
        @(posedge clk_i);
        #1;

        // Basic frame, ready_i held high.
        for (int i = 0; i < 4; i++) send(f1[i], 0);
        wait_k(16);
        for (int i = 0; i < 16; i++) chk("t1_lit_data", log_d[i], exp16[i]);
        chk("t1_col5", log_c[5], 1);
        chk("t1_row5", log_r[5], 1);
        chk("t1_col15", log_c[15], 3);
        chk("t1_row15", log_r[15], 3);

        // Same stream with downstream toggling.
        tog = 1'b1;
        for (int i = 0; i < 4; i++) send(f1[i], 0);
        wait_k(32);
        tog = 1'b0;
        for (int i = 0; i < 16; i++) chk("t2_lit_data", log_d[16 + i], exp16[i]);

        // Source gaps produce bubbles.
        for (int i = 0; i < 4; i++) send(f3[i], 3);
        wait_k(48);
        chk("t3_lit_px3", log_d[32 + 10], 16'h3888);

        // Two frames back to back, across the wrap.
        for (int i = 0; i < 8; i++) send(f4[i], 0);
        wait_k(80);
        repeat (5) @(posedge clk_i);
        #1;
        chk("t4_total", k, 80);
        chk("t4_wrap_col_last", log_c[63], 3);
        chk("t4_wrap_row_last", log_r[63], 3);
        chk("t4_wrap_col0", log_c[64], 0);
        chk("t4_wrap_row0", log_r[64], 0);
        chk("t4_wrap_data", log_d[64], 16'h2111);

        // Reset mid-frame, then special values pass bit-exact.
        for (int i = 0; i < 3; i++) send(16'h5000 + 16'(i * 16'h0100), 0);
        wait_k(85);
        do_reset();
        for (int i = 0; i < 4; i++) send(f5[i], 0);
        wait_k(16);
        chk("t5_first_data", log_d[0], 16'h7E00);
        chk("t5_first_col", log_c[0], 0);
        chk("t5_first_row", log_r[0], 0);
        chk("t5_negzero", log_d[2], 16'h8000);
        chk("t5_inf", log_d[8], 16'h7C00);
        chk("t5_subnormal", log_d[10], 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/zero_insert_upsampler_fp16.md
# zero_insert_upsampler_fp16

- Streams a W×H fp16 image in and emits a 2W×2H image.
- Input pixels land at even (col, row) coordinates; every other position carries +0.0.
- Each output beat carries its col/row coordinates.
- Sits directly upstream of the 3×3 window generator that feeds the `[0.25 0.5 0.25; 0.5 1 0.5; 0.25 0.5 0.25]` upsampling convolution. Zero insertion followed by that kernel yields bilinear interpolation.

## Interface
- EXP_WIDTH, 5, exponent bits
- FRAC_WIDTH, 10, fraction bits
- IN_WIDTH, 320, input image width in pixels; 2·IN_WIDTH ≤ 65536
- IN_HEIGHT, 240, input image height in pixels; 2·IN_HEIGHT ≤ 65536
- FP_WIDTH_REG, 1+EXP_WIDTH+FRAC_WIDTH, local: word width
- clk_i  in  1  single clock; all state rising-edge
- rst_i  in  1  reset, asynchronous, active-low
- data_i  in  FP_WIDTH_REG  input pixel, raster order
- valid_i  in  1  data_i valid
- ready_o  out  1  block accepts data_i this cycle
- data_o  out  FP_WIDTH_REG  output pixel
- col_o  out  16  output column, 0..2·IN_WIDTH−1
- row_o  out  16  output row, 0..2·IN_HEIGHT−1
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream accepts output beat

## Operation
- Output stage is a single register set: data_o, col_o, row_o, valid_o. It loads when `!valid_o || ready_i` ("advance").
- Internal counters:
  - col_q, 0..2W−1
  - row_q, 0..2H−1
  - state ∈ {EVEN_PIX, EVEN_ZERO, ODD_ROW}
- EVEN_PIX (row even, col even):
  - ready_o = advance.
  - On valid_i && ready_o: load data_i with (col_q, row_q), set valid_o, increment col, go to EVEN_ZERO.
  - If valid_i is low and advance holds: valid_o ← 0 and counters hold (bubble).
- EVEN_ZERO (col odd): on advance, load 16'h0000, valid_o ← 1, then increment col.
  - Not last column → EVEN_PIX.
  - Last column → col ← 0, row++ → ODD_ROW.
- ODD_ROW: on advance, emit 16'h0000 for each col 0..2W−1.
  - At the end: col ← 0 and row++.
  - If the row was 2H−1 → row ← 0 and → EVEN_PIX (next frame, no gap).
  - Otherwise → EVEN_PIX.
- ready_o is 0 in EVEN_ZERO and ODD_ROW.
- data_i is passed bit-exact, including NaN, Inf, −0 and subnormals. No arithmetic is performed on pixel data.
- Per frame: exactly W·H inputs consumed and 4·W·H outputs emitted.

## Timing
- Reset (rst_i low, async) forces:
  - valid_o=0, data_o=0, col_o=0, row_o=0
  - col_q=0, row_q=0, state=EVEN_PIX
  - ready_o=0 while rst_i is low
- First cycle after release: ready_o = 1.
- Latency: input accepted on cycle n → valid_o with that pixel on cycle n+1.
- Throughput: one output per cycle while ready_i=1 and the source never starves.
  - Even rows accept input every other cycle.
  - Odd rows accept none.
- Stall (valid_o && !ready_i): all outputs and counters hold, ready_o=0.
- Wrap: the beat after (2W−1, 2H−1) is (0, 0) of the next frame.
- Reset mid-frame: the partial frame is discarded. The next accepted input is pixel (0,0) of a fresh frame.

## Configuration
- `ZERO_INSERT_FRAME_FLAGS_EN`: adds outputs sof_o (1 bit, high with the beat at (0,0)) and eol_o (1 bit, high with any beat at col 2W−1).
  - Both are registered alongside data_o, reset to 0, and follow the same hold rules.
- Without the macro, neither port exists and behaviour is otherwise identical.

## Structure
- Shared package `upsampler_pkg`:
  - state enum `zi_state_t`
  - `FP16_POS_ZERO` = 16'h0000
  - coordinate width constant `COORD_W` = 16
- One natural sub-module, `upsample_coord_counter`: col/row counters with an advance enable, producing last_col/last_row flags and frame wrap.

## Test plan
- W=2, H=2, inputs 3C00, 4000, 4200, 4400, ready_i=1 → 16 beats:
  - row0: 3C00, 0, 4000, 0
  - row1: all 0
  - row2: 4200, 0, 4400, 0
  - row3: all 0
  - col/row increment correctly and ready_o follows 1-0-1-0 on even rows.
- Same stream, ready_i toggling 1,0 each cycle → identical beat sequence; outputs stable during every ready_i=0 cycle.
- valid_i gaps of 3 cycles in EVEN_PIX → valid_o bubbles; col_o/row_o never skip.
- Two back-to-back frames → after (3,3) next beat is (0,0) carrying the first pixel of frame 2; 32 outputs total.
- rst_i low after 5 outputs, then released → all outputs 0 during reset; first output after release is (0,0) with the next accepted input.
- Input 7E00 (NaN) and 8000 (−0) → appear unchanged at data_o. With macro: sof_o on (0,0), eol_o on col 3.
